// File: rtl/ppu_bg_pipeline.sv
// Background tile fetcher and pixel FIFO for PPU draw mode: scroll-aware map/tile
// fetches, 8-pixel FIFO pushes, fine-scroll discard and BGP palette mapping.
module ppu_bg_pipeline #(
  parameter int FIFO_DEPTH = 16,
  parameter int SCREEN_W   = 160,
  parameter int MEM_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [7:0]  ly,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic        bg_map_sel,
  input  logic        tile_data_sel,
  input  logic [7:0]  bgp,
  output logic        vram_rd,
  output logic [15:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic [1:0]  px_out,
  output logic        px_valid,
  output logic        busy,
  output logic        line_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = $clog2(SCREEN_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_MAP, S_LO, S_HI, S_PUSH} state_t;
  state_t state, state_nxt;

  logic [1:0]    wcnt;
  logic [7:0]    y_r;
  logic [2:0]    fine_r;
  logic [4:0]    col0_r, fetch_idx, col;
  logic          map_sel_r, data_sel_r;
  logic [7:0]    tile_no, lo_r, hi_r;
  logic [1:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, free;
  logic [2:0]    disc_cnt;
  logic [EW-1:0] emit_cnt;

  logic          rd_state, rd_last, push_ok, push, pop, discard, end_line;
  logic [15:0]   map_addr, tile_base, row_addr;
  logic [1:0]    pop_idx;

  assign rd_state = (state == S_MAP) || (state == S_LO) || (state == S_HI);
  assign vram_rd  = rd_state && (wcnt == 2'd0);
  assign rd_last  = rd_state && (wcnt == 2'(MEM_LAT));
  // Free space uses the pre-pop count; a same-cycle pop is deliberately not credited.
  assign free     = CW'(FIFO_DEPTH) - count;
  assign end_line = px_valid && (emit_cnt == EW'(SCREEN_W));
  assign push_ok  = (state == S_PUSH) && (free >= CW'(8));
  assign push     = push_ok && !line_start && !end_line;
  assign pop      = busy && (count != '0) && (emit_cnt < EW'(SCREEN_W)) && !line_start;
  assign discard  = disc_cnt < fine_r;
  assign pop_idx  = fifo[rd_ptr];

  assign col       = col0_r + fetch_idx;
  assign map_addr  = (map_sel_r ? 16'h9C00 : 16'h9800) + {6'b0, y_r[7:3], 5'b0} + {11'b0, col};
  assign tile_base = data_sel_r ? 16'h8000 + {4'b0, tile_no, 4'b0}
                                : 16'h9000 + {{4{tile_no[7]}}, tile_no, 4'b0};
  assign row_addr  = tile_base + {12'b0, y_r[2:0], 1'b0};

  always_comb begin
    vram_addr = '0;
    if (vram_rd) begin
      case (state)
        S_MAP:   vram_addr = map_addr;
        S_LO:    vram_addr = row_addr;
        S_HI:    vram_addr = row_addr + 16'd1;
        default: vram_addr = '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_MAP:   if (rd_last) state_nxt = S_LO;
      S_LO:    if (rd_last) state_nxt = S_HI;
      S_HI:    if (rd_last) state_nxt = S_PUSH;
      S_PUSH:  if (push_ok) state_nxt = S_MAP;
      default: state_nxt = state;
    endcase
    if (end_line)   state_nxt = S_IDLE;
    if (line_start) state_nxt = S_MAP;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned i = 0; i < 8; i++)
        fifo[wr_ptr + PW'(i)] <= {hi_r[3'(7 - i)], lo_r[3'(7 - i)]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      y_r        <= '0;
      fine_r     <= '0;
      col0_r     <= '0;
      map_sel_r  <= 1'b0;
      data_sel_r <= 1'b0;
      fetch_idx  <= '0;
      tile_no    <= '0;
      lo_r       <= '0;
      hi_r       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      disc_cnt   <= '0;
      emit_cnt   <= '0;
      px_out     <= '0;
      px_valid   <= 1'b0;
      busy       <= 1'b0;
      line_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= (line_start || end_line || !rd_state || rd_last) ? 2'd0 : wcnt + 2'd1;
      if (line_start) begin
        y_r        <= ly + scy;
        fine_r     <= scx[2:0];
        col0_r     <= scx[7:3];
        map_sel_r  <= bg_map_sel;
        data_sel_r <= tile_data_sel;
        fetch_idx  <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        disc_cnt   <= '0;
        emit_cnt   <= '0;
        px_valid   <= 1'b0;
        busy       <= 1'b1;
        line_done  <= 1'b0;
      end else if (end_line) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        px_valid  <= 1'b0;
        busy      <= 1'b0;
        line_done <= 1'b1;
      end else begin
        line_done <= 1'b0;
        if (rd_last) begin
          case (state)
            S_MAP:   tile_no <= vram_data;
            S_LO:    lo_r    <= vram_data;
            default: hi_r    <= vram_data;
          endcase
        end
        if (push) begin
          wr_ptr    <= wr_ptr + PW'(8);
          fetch_idx <= fetch_idx + 5'd1;
        end
        px_valid <= 1'b0;
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
          if (discard) begin
            disc_cnt <= disc_cnt + 3'd1;
          end else begin
            px_out   <= bgp[{pop_idx, 1'b1} -: 2];
            px_valid <= 1'b1;
            emit_cnt <= emit_cnt + EW'(1);
          end
        end
        count <= count + (push ? CW'(8) : CW'(0)) - (pop ? CW'(1) : CW'(0));
      end
    end
  end
endmodule

// File: tb/tb_ppu_bg_pipeline.sv
// Bench for ppu_bg_pipeline: a fast (MEM_LAT=1, 16-deep) and a slow (MEM_LAT=3, 8-deep)
// instance share stimulus; a per-pixel background model feeds scoreboard queues.
module tb_ppu_bg_pipeline;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic [7:0]  ly = '0, scx = '0, scy = '0, bgp = '0;
  logic        bg_map_sel = 1'b0, tile_data_sel = 1'b0;

  logic        vram_rd_a, vram_rd_b, px_valid_a, px_valid_b;
  logic        busy_a, busy_b, line_done_a, line_done_b;
  logic [15:0] vram_addr_a, vram_addr_b;
  logic [7:0]  vram_data_a, vram_data_b;
  logic [1:0]  px_out_a, px_out_b;

  logic [7:0]  mem [0:8191];
  logic [7:0]  pa [3];
  logic [7:0]  pb [3];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ppu_bg_pipeline #(.FIFO_DEPTH(16), .SCREEN_W(160), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .line_start(line_start), .ly(ly), .scx(scx), .scy(scy),
    .bg_map_sel(bg_map_sel), .tile_data_sel(tile_data_sel), .bgp(bgp),
    .vram_rd(vram_rd_a), .vram_addr(vram_addr_a), .vram_data(vram_data_a),
    .px_out(px_out_a), .px_valid(px_valid_a), .busy(busy_a), .line_done(line_done_a));

  ppu_bg_pipeline #(.FIFO_DEPTH(8), .SCREEN_W(160), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .line_start(line_start), .ly(ly), .scx(scx), .scy(scy),
    .bg_map_sel(bg_map_sel), .tile_data_sel(tile_data_sel), .bgp(bgp),
    .vram_rd(vram_rd_b), .vram_addr(vram_addr_b), .vram_data(vram_data_b),
    .px_out(px_out_b), .px_valid(px_valid_b), .busy(busy_b), .line_done(line_done_b));

  // VRAM models: data appears MEM_LAT cycles after the issue cycle.
  always @(posedge clk) begin
    pa[0] <= mem[vram_addr_a[12:0]];
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pb[0] <= mem[vram_addr_b[12:0]];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign vram_data_a = pa[0];
  assign vram_data_b = pb[2];

  typedef struct {
    logic [7:0]  ly, scx, scy, bgp;
    logic        msel, dsel;
    logic [7:0]  tile;
    logic [15:0] a0, a1, a2, a3;
    int          first;
  } vec_t;
  vec_t tv [6];

  logic [1:0] q_a [$];
  logic [1:0] q_b [$];
  logic [1:0] exp8 [8];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_pix(input vec_t v, input int x);
    logic [7:0] p, yy, t, lo, hi;
    int ma, ta, ii;
    logic [2:0] b;
    p  = v.scx + 8'(x);
    yy = v.ly + v.scy;
    ma = (v.msel ? 'h9C00 : 'h9800) + 32 * int'(yy[7:3]) + int'(p[7:3]);
    t  = mem[ma - 'h8000];
    ta = v.dsel ? 'h8000 + 16 * int'(t) : 'h9000 + 16 * int'($signed(t));
    ta = (ta & 'hFFFF) + 2 * int'(yy[2:0]);
    lo = mem[ta - 'h8000];
    hi = mem[ta + 1 - 'h8000];
    b  = 3'd7 - p[2:0];
    ii = int'({hi[b], lo[b]});
    return v.bgp[2*ii +: 2];
  endfunction

  task automatic drive_line(input int v);
    ly = tv[v].ly; scx = tv[v].scx; scy = tv[v].scy; bgp = tv[v].bgp;
    bg_map_sel = tv[v].msel; tile_data_sel = tv[v].dsel;
    line_start = 1'b1;
    q_a.delete();
    q_b.delete();
    for (int x = 0; x < 160; x++) begin
      q_a.push_back(exp_pix(tv[v], x));
      q_b.push_back(exp_pix(tv[v], x));
    end
  endtask

  task automatic run_line(input int v, input int abort_at, input int av, output int gaps_b);
    int cyc, nrd, rd_cyc0, cnt_a, cnt_b, first_a, last_a, last_b, gaps_a, cur;
    bit done_a, done_b;
    logic [15:0] rd [4];
    cur = v; nrd = 0; rd_cyc0 = -1; cnt_a = 0; cnt_b = 0; first_a = -1;
    last_a = 0; last_b = 0; gaps_a = 0; gaps_b = 0; done_a = 0; done_b = 0;
    for (int k = 0; k < 4; k++) rd[k] = '0;
    @(negedge clk);
    drive_line(v);
    @(negedge clk);
    line_start = 1'b0;
    cyc = 1;
    while (!(done_a && done_b) && cyc < 3000) begin
      if (cyc == 1) check("busy_at_cycle1", int'(busy_a), 1);
      if (vram_rd_a && nrd < 4) begin
        rd[nrd] = vram_addr_a;
        if (nrd == 0) rd_cyc0 = cyc;
        nrd++;
      end
      if (px_valid_a) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL extra_pixel_a: pixel %0d beyond 160", cnt_a + 1);
        end else check("pix_a", int'(px_out_a), int'(q_a.pop_front()));
        if (v == 0 && abort_at == 0 && cnt_a < 8)
          check("first8_a", int'(px_out_a), int'(exp8[cnt_a]));
        cnt_a++;
        if (cnt_a == 1) first_a = cyc;
        else if (cyc != last_a + 1) gaps_a++;
        last_a = cyc;
      end
      if (px_valid_b) begin
        if (q_b.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL extra_pixel_b: pixel %0d beyond 160", cnt_b + 1);
        end else check("pix_b", int'(px_out_b), int'(q_b.pop_front()));
        cnt_b++;
        if (cnt_b > 1 && cyc != last_b + 1) gaps_b++;
        last_b = cyc;
      end
      if (line_done_a) begin
        check("done_a_count", cnt_a, 160);
        check("done_a_timing", cyc, last_a + 1);
        check("done_a_busy", int'(busy_a), 0);
        done_a = 1;
      end
      if (line_done_b) begin
        check("done_b_count", cnt_b, 160);
        check("done_b_timing", cyc, last_b + 1);
        done_b = 1;
      end
      if (abort_at != 0 && cur == v && cyc == abort_at) begin
        drive_line(av);
        cur = av; cyc = 0; nrd = 0; rd_cyc0 = -1; cnt_a = 0; cnt_b = 0;
        first_a = -1; gaps_a = 0; gaps_b = 0;
      end
      @(negedge clk);
      line_start = 1'b0;
      cyc++;
    end
    check("line_finished_a", int'(done_a), 1);
    check("line_finished_b", int'(done_b), 1);
    check("map_issue_cycle", rd_cyc0, 1);
    check("rd0_map", int'(rd[0]), int'(tv[cur].a0));
    check("rd1_lo", int'(rd[1]), int'(tv[cur].a1));
    check("rd2_hi", int'(rd[2]), int'(tv[cur].a2));
    check("rd3_map2", int'(rd[3]), int'(tv[cur].a3));
    check("first_valid_cycle", first_a, tv[cur].first);
    check("contiguous_a", gaps_a, 0);
  endtask

  initial begin
    int gb, gsum;
    tv[0] = '{8'h00, 8'h00, 8'h00, 8'hE4, 1'b0, 1'b1, 8'h01, 16'h9800, 16'h8010, 16'h8011, 16'h9801, 9};
    tv[1] = '{8'h00, 8'hFD, 8'h00, 8'hE4, 1'b0, 1'b1, 8'h01, 16'h981F, 16'h8010, 16'h8011, 16'h9800, 14};
    tv[2] = '{8'h03, 8'h00, 8'h00, 8'h6C, 1'b1, 1'b0, 8'h80, 16'h9C00, 16'h8806, 16'h8807, 16'h9C01, 9};
    tv[3] = '{8'h03, 8'h08, 8'h00, 8'hE4, 1'b0, 1'b0, 8'h7F, 16'h9801, 16'h97F6, 16'h97F7, 16'h9802, 9};
    tv[4] = '{8'h10, 8'h13, 8'hF5, 8'h1B, 1'b1, 1'b1, 8'h22, 16'h9C02, 16'h822A, 16'h822B, 16'h9C03, 12};
    tv[5] = '{8'hF8, 8'hF8, 8'h10, 8'h93, 1'b0, 1'b1, 8'h05, 16'h983F, 16'h8050, 16'h8051, 16'h9820, 9};
    exp8 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    for (int v = 0; v < 6; v++) mem[int'(tv[v].a0) - 'h8000] = tv[v].tile;
    mem['h0010] = 8'hF0;
    mem['h0011] = 8'h0F;

    repeat (3) @(negedge clk);
    check("reset_a", int'({px_out_a, px_valid_a, busy_a, line_done_a, vram_rd_a, vram_addr_a}), 0);
    check("reset_b", int'({px_out_b, px_valid_b, busy_b, line_done_b, vram_rd_b, vram_addr_b}), 0);
    rst = 1'b0;

    gsum = 0;
    for (int v = 0; v < 6; v++) begin
      run_line(v, 0, 0, gb);
      gsum += gb;
    end
    check("gaps_b_present", int'(gsum > 0), 1);

    // Restart at cycle 50 of a line; MAP for the new line must issue in cycle 51.
    run_line(0, 50, 4, gb);

    // Asynchronous reset mid-line.
    @(negedge clk);
    drive_line(2);
    @(negedge clk);
    line_start = 1'b0;
    repeat (30) @(negedge clk);
    check("busy_before_rst", int'(busy_a), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_a", int'({px_out_a, px_valid_a, busy_a, line_done_a, vram_rd_a, vram_addr_a}), 0);
    check("async_rst_b", int'({px_out_b, px_valid_b, busy_b, line_done_b, vram_rd_b, vram_addr_b}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
